// File: rtl/cryptopro_pkg.sv
// Shared definitions for the datapath result path.
// Holds the result/word geometry and the two-state control encoding.
// The mux_in control decode uses the same encoding.
//   DW      result width in bits
//   WW      host word width in bits
//   NWORDS  beats per result (derived)
//   IDXW    width of a beat index
//   SW      width of the padded shift register (NWORDS*WW)
//   PADW    zero padding above the result inside the shift register
package cryptopro_pkg;

    localparam int DW     = 1506;
    localparam int WW     = 64;
    localparam int NWORDS = (DW + WW - 1) / WW;
    localparam int IDXW   = $clog2(NWORDS);
    localparam int SW     = NWORDS * WW;
    localparam int PADW   = SW - DW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mux_out_unloader.sv
// mux_out_unloader
// Captures one DW-bit datapath result and streams it to the host LSW-first
// as NWORDS beats of WW bits over a valid/ready handshake.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   cap_valid  result on cap_data is valid
//   cap_ready  unloader can accept a result (high in IDLE)
//   cap_data   result to unload
//   abort      synchronous flush of the current unload
//   o_valid    o_word holds a valid beat
//   o_ready    host accepts the beat
//   o_word     current beat, LSW first; zero when o_valid is low
//   o_idx      index of current beat
//   o_last     current beat is the final one
//   busy       unload in progress
module mux_out_unloader
    import cryptopro_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_valid,
    output logic              cap_ready,
    input  logic [DW-1:0]     cap_data,
    input  logic              abort,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [WW-1:0]     o_word,
    output logic [IDXW-1:0]   o_idx,
    output logic              o_last,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     sreg;
    logic [IDXW-1:0]   idx;

    logic              capture;
    logic              beat_fire;
    logic              last_beat;

    // Abort outranks both the capture and the beat handshake.
    always_comb begin
        last_beat = (idx == IDXW'(NWORDS - 1));
        capture   = (state == IDLE) && cap_valid && !abort;
        beat_fire = (state == SEND) && o_ready && !abort;
    end

    // State register, shift register and beat index.
    // o_idx doubles as the beat counter, so no separate counter is kept.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                sreg <= {{PADW{1'b0}}, cap_data};
                idx  <= '0;
            end else if (beat_fire) begin
                if (last_beat) begin
                    sreg <= '0;
                    idx  <= '0;
                end else begin
                    sreg <= sreg >> WW;
                    idx  <= idx + IDXW'(1);
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (state == IDLE) begin
            if (cap_valid) begin
                state_next = SEND;
            end
        end else begin
            if (o_ready && last_beat) begin
                state_next = IDLE;
            end
        end
    end

    // Outputs. o_word is gated so it reads zero whenever no beat is offered.
    always_comb begin
        cap_ready = (state == IDLE);
        o_valid   = (state == SEND);
        busy      = (state == SEND);
        o_idx     = idx;
        o_last    = (state == SEND) && last_beat;
        o_word    = (state == SEND) ? sreg[WW-1:0] : '0;
    end

endmodule

// File: tb/tb_mux_out_unloader.sv
// Directed testbench for mux_out_unloader.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mux_out_unloader;
    import cryptopro_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cap_valid;
    logic              cap_ready;
    logic [DW-1:0]     cap_data;
    logic              abort;
    logic              o_valid;
    logic              o_ready;
    logic [WW-1:0]     o_word;
    logic [IDXW-1:0]   o_idx;
    logic              o_last;
    logic              busy;

    int n_vec  = 0;
    int n_miss = 0;

    mux_out_unloader dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .abort     (abort),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_word    (o_word),
        .o_idx     (o_idx),
        .o_last    (o_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_result();
        logic [SW-1:0] t;
        for (int i = 0; i < SW / 32; i++) begin
            t[32*i +: 32] = $urandom;
        end
        return t[DW-1:0];
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cap_ready"}, 64'(cap_ready), 64'd1);
        chk({tag, "_o_valid"},   64'(o_valid),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_o_last"},    64'(o_last),    64'd0);
        chk({tag, "_o_idx"},     64'(o_idx),     64'd0);
        chk({tag, "_o_word"},    o_word,         64'd0);
    endtask

    // Present a result for one capture edge; returns at the negedge where beat 0 shows.
    task automatic do_capture(input logic [DW-1:0] d);
        cap_valid = 1'b1;
        cap_data  = d;
        @(negedge clk);
        cap_valid = 1'b0;
    endtask

    // Expects o_ready=1 and beat 0 visible; returns with beat NWORDS-1 visible.
    task automatic check_stream(input string tag, input logic [DW-1:0] d);
        logic [SW-1:0] ap;
        ap = {{PADW{1'b0}}, d};
        for (int k = 0; k < NWORDS; k++) begin
            chk({tag, "_valid"}, 64'(o_valid), 64'd1);
            chk({tag, "_idx"},   64'(o_idx),   64'(k));
            chk({tag, "_last"},  64'(o_last),  64'(k == NWORDS - 1));
            chk({tag, "_word"},  o_word,       ap[64*k +: 64]);
            if (k == 0)
                chk({tag, "_beat0"}, o_word, d[63:0]);
            if (k == NWORDS - 1)
                chk({tag, "_beat23"}, o_word, {30'b0, d[1505:1472]});
            if (k < NWORDS - 1)
                @(negedge clk);
        end
    endtask

    logic [DW-1:0] a_res, b_res, c_res, d_res, e_res, g_res, h_res;
    logic [SW-1:0] reasm;
    time           t0;

    initial begin
        rst       = 1'b1;
        cap_valid = 1'b0;
        cap_data  = '0;
        abort     = 1'b0;
        o_ready   = 1'b0;

        // 1: reset
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // 2: full stream with o_ready held high
        a_res   = rnd_result();
        o_ready = 1'b1;
        do_capture(a_res);
        check_stream("stream", a_res);
        @(negedge clk);
        chk("stream_idle_valid", 64'(o_valid), 64'd0);
        chk("stream_idle_ready", 64'(cap_ready), 64'd1);
        chk("stream_idle_word",  o_word, 64'd0);

        // 3: backpressure pattern 1,0,0,1,0,0,...
        b_res   = rnd_result();
        o_ready = 1'b0;
        do_capture(b_res);
        begin
            int           nb;
            int           cyc;
            bit           stalled;
            logic [63:0]  pw;
            logic [4:0]   pi;
            nb      = 0;
            cyc     = 0;
            stalled = 1'b0;
            pw      = '0;
            pi      = '0;
            reasm   = '0;
            while (o_valid && cyc < 200) begin
                if (stalled) begin
                    chk("bp_hold_word", o_word, pw);
                    chk("bp_hold_idx",  64'(o_idx), 64'(pi));
                end
                chk("bp_idx", 64'(o_idx), 64'(nb));
                chk("bp_last", 64'(o_last), 64'(nb == NWORDS - 1));
                o_ready = (cyc % 3 == 0);
                if (o_ready) begin
                    if (nb < NWORDS)
                        reasm[64*nb +: 64] = o_word;
                    nb++;
                end
                stalled = !o_ready;
                pw      = o_word;
                pi      = o_idx;
                cyc++;
                @(negedge clk);
            end
            chk("bp_timeout", 64'(cyc < 200), 64'd1);
            chk("bp_count", 64'(nb), 64'(NWORDS));
            chk("bp_reasm", 64'(reasm == {{PADW{1'b0}}, b_res}), 64'd1);
            chk("bp_idle", 64'(o_valid), 64'd0);
        end

        // 4: abort at beat 10, then a fresh stream
        c_res   = rnd_result();
        o_ready = 1'b1;
        do_capture(c_res);
        repeat (10) @(negedge clk);
        chk("abort_at_idx", 64'(o_idx), 64'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_cap_ready", 64'(cap_ready), 64'd1);
        chk("abort_idx", 64'(o_idx), 64'd0);
        chk("abort_word", o_word, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        d_res = rnd_result();
        do_capture(d_res);
        check_stream("after_abort", d_res);
        @(negedge clk);

        // abort in IDLE suppresses a simultaneous capture
        abort     = 1'b1;
        cap_valid = 1'b1;
        cap_data  = rnd_result();
        @(negedge clk);
        abort     = 1'b0;
        cap_valid = 1'b0;
        chk("idle_abort_valid", 64'(o_valid), 64'd0);
        chk("idle_abort_ready", 64'(cap_ready), 64'd1);

        // 5: capture during SEND ignored; held cap_valid accepted after last beat
        e_res     = rnd_result();
        g_res     = rnd_result();
        t0        = $time;
        cap_valid = 1'b1;
        cap_data  = e_res;
        @(negedge clk);
        cap_data  = g_res;
        check_stream("ignored", e_res);
        @(negedge clk);
        chk("b2b_gap_ready", 64'(cap_ready), 64'd1);
        chk("b2b_gap_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        cap_valid = 1'b0;
        check_stream("b2b", g_res);
        chk("b2b_cycles", 64'(($time - t0) / 10), 64'(2 * NWORDS + 1));
        @(negedge clk);

        // 6: reset mid-stream at beat 5
        h_res = rnd_result();
        do_capture(h_res);
        repeat (5) @(negedge clk);
        chk("rst_mid_idx", 64'(o_idx), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", 64'(o_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
